mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10: line-index width for all address ports.
REQ-002 Parameter LINE_W, default 128: cache-line width for all data ports.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 Ic_mem_req  input  1  I-cache line-read request, held high until F_mem_valid.
REQ-006 Ic_mem_addr  input  ADDR_W  I-cache line index.
REQ-007 F_mem_inst  output  LINE_W  instruction line returned to I-cache.
REQ-008 F_mem_valid  output  1  one-cycle pulse; F_mem_inst valid.
REQ-009 Dc_mem_req  input  1  D-cache line-read request, held high until MEM_mem_valid.
REQ-010 Dc_mem_addr  input  ADDR_W  D-cache read line index.
REQ-011 MEM_data_line  output  LINE_W  data line returned to D-cache.
REQ-012 MEM_mem_valid  output  1  one-cycle pulse; MEM_data_line valid.
REQ-013 Dc_wb_we  input  1  D-cache write-back request, held high until Dc_wb_done.
REQ-014 Dc_wb_addr  input  ADDR_W  write-back line index.
REQ-015 Dc_wb_wline  input  LINE_W  write-back line data.
REQ-016 Dc_wb_done  output  1  one-cycle pulse; write-back committed.
REQ-017 Arb_mem_req  output  1  request to single-port backing memory, held until Arb_mem_valid.
REQ-018 Arb_mem_we  output  1  1 = write, 0 = read.
REQ-019 Arb_mem_addr  output  ADDR_W  backing-memory line index.
REQ-020 Arb_mem_wline  output  LINE_W  write data.
REQ-021 Arb_mem_rline  input  LINE_W  read data; sampled only when Arb_mem_valid is high.
REQ-022 Arb_mem_valid  input  1  one-cycle completion pulse for read or write.

Function
REQ-023 FSM states: IDLE, BUSY_I, BUSY_DR, BUSY_DW; exactly one memory transaction is outstanding at a time.
REQ-024 In IDLE, priority is write-back > {D-read, I-read}.
REQ-025 When D-read and I-read are both eligible with no write-back, the grant goes to the one not granted last (1-bit last_grant; reset value grants D first).
REQ-026 A requester whose valid/done pulse is high in the current cycle is ineligible that cycle, so held-over requests never re-grant.
REQ-027 On grant at edge n, Arb_mem_req/we/addr/wline are registered from the winner's inputs and are high in cycle n+1.
REQ-028 These outputs stay stable until the cycle Arb_mem_valid is sampled high.
REQ-029 On Arb_mem_valid at edge k, Arb_mem_req deasserts, the FSM returns to IDLE, and the matching response pulses high for exactly cycle k+1.
REQ-030 Read responses register Arb_mem_rline into F_mem_inst or MEM_data_line.
REQ-031 The next grant is evaluated in cycle k+1, subject to REQ-026; the earliest new Arb_mem_req is cycle k+2.
REQ-032 F_mem_inst and MEM_data_line hold their last value between pulses.
REQ-033 If a requester drops its request mid-transaction, the transaction still completes and its pulse is still issued.
REQ-034 Arb_mem_valid received in IDLE is ignored; no response pulse, no state change.
REQ-035 A write-back arriving while a read is outstanding waits; it preempts nothing already issued.
REQ-036 Addresses are passed through unmodified; no width conversion.

Reset
REQ-037 While rst=0: FSM=IDLE, last_grant=I (D wins first tie), and all outputs are 0, including F_mem_inst and MEM_data_line.
REQ-038 Reset mid-transaction aborts it immediately; no response pulse is issued for the aborted transaction.
REQ-039 After rst rises, the first grant is evaluated on the first rising edge with rst=1.

Verification
REQ-040 Single I-read, addr 0x004, memory latency 3: Arb_mem_req high cycles 1-4, we=0, addr=0x004; F_mem_valid high only cycle 5 with returned line.
REQ-041 Ic_mem_req and Dc_mem_req both rise in cycle 0, held until served: D served first, then I; Arb_mem_req low exactly one cycle between transactions; one pulse each.
REQ-042 Write-back (addr 0x010, line 0xA5..A5) plus both reads pending: write-back granted first (Arb_mem_we=1, wline matches); Dc_wb_done one pulse; then D-read, then I-read.
REQ-043 Continuous Ic_mem_req and Dc_mem_req, reasserted immediately after each pulse: grants alternate D, I, D, I over 8 transactions; none re-granted back-to-back.
REQ-044 rst driven low during BUSY_DR, one cycle before Arb_mem_valid: all outputs 0 asynchronously; no MEM_mem_valid pulse; late Arb_mem_valid after release ignored.
REQ-045 Ic_mem_req dropped mid-transaction: F_mem_valid still pulses once; FSM back in IDLE; no further Arb_mem_req.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response and backing-memory bundle for mem_arbiter
// slave: the arbiter's view; master: caches plus backing memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int LINE_W = 128
);
    logic              Ic_mem_req;
    logic [ADDR_W-1:0] Ic_mem_addr;
    logic [LINE_W-1:0] F_mem_inst;
    logic              F_mem_valid;
    logic              Dc_mem_req;
    logic [ADDR_W-1:0] Dc_mem_addr;
    logic [LINE_W-1:0] MEM_data_line;
    logic              MEM_mem_valid;
    logic              Dc_wb_we;
    logic [ADDR_W-1:0] Dc_wb_addr;
    logic [LINE_W-1:0] Dc_wb_wline;
    logic              Dc_wb_done;
    logic              Arb_mem_req;
    logic              Arb_mem_we;
    logic [ADDR_W-1:0] Arb_mem_addr;
    logic [LINE_W-1:0] Arb_mem_wline;
    logic [LINE_W-1:0] Arb_mem_rline;
    logic              Arb_mem_valid;

    modport slave (
        input  Ic_mem_req, Ic_mem_addr, Dc_mem_req, Dc_mem_addr,
        input  Dc_wb_we, Dc_wb_addr, Dc_wb_wline, Arb_mem_rline, Arb_mem_valid,
        output F_mem_inst, F_mem_valid, MEM_data_line, MEM_mem_valid, Dc_wb_done,
        output Arb_mem_req, Arb_mem_we, Arb_mem_addr, Arb_mem_wline
    );

    modport master (
        output Ic_mem_req, Ic_mem_addr, Dc_mem_req, Dc_mem_addr,
        output Dc_wb_we, Dc_wb_addr, Dc_wb_wline, Arb_mem_rline, Arb_mem_valid,
        input  F_mem_inst, F_mem_valid, MEM_data_line, MEM_mem_valid, Dc_wb_done,
        input  Arb_mem_req, Arb_mem_we, Arb_mem_addr, Arb_mem_wline
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter of I-read, D-read and D write-back onto one memory port
// Write-back wins outright; reads alternate on ties via last_grant_d.
module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int LINE_W = 128
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_DR, BUSY_DW} state_t;

    state_t            state, state_next;
    logic              last_grant_d;
    logic              ic_elig, dc_elig, wb_elig;
    logic              grant_i, grant_dr, grant_dw, done;
    logic              req_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wline_q, f_line_q, d_line_q;
    logic              f_valid_q, d_valid_q, wb_done_q;

    // A requester being answered this cycle is still holding its request; mask it.
    assign ic_elig = bus.Ic_mem_req && !f_valid_q;
    assign dc_elig = bus.Dc_mem_req && !d_valid_q;
    assign wb_elig = bus.Dc_wb_we   && !wb_done_q;

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_dr   = 1'b0;
        grant_dw   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (wb_elig) begin
                    grant_dw   = 1'b1;
                    state_next = BUSY_DW;
                end else if (dc_elig && (!ic_elig || !last_grant_d)) begin
                    grant_dr   = 1'b1;
                    state_next = BUSY_DR;
                end else if (ic_elig) begin
                    grant_i    = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_DR, BUSY_DW: begin
                if (bus.Arb_mem_valid) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wline_q      <= '0;
            f_line_q     <= '0;
            d_line_q     <= '0;
            f_valid_q    <= 1'b0;
            d_valid_q    <= 1'b0;
            wb_done_q    <= 1'b0;
            last_grant_d <= 1'b0;
        end else begin
            f_valid_q <= done && (state == BUSY_I);
            d_valid_q <= done && (state == BUSY_DR);
            wb_done_q <= done && (state == BUSY_DW);
            if (done) begin
                req_q <= 1'b0;
            end else if (grant_i || grant_dr || grant_dw) begin
                req_q   <= 1'b1;
                we_q    <= grant_dw;
                addr_q  <= grant_dw ? bus.Dc_wb_addr : (grant_dr ? bus.Dc_mem_addr : bus.Ic_mem_addr);
                wline_q <= grant_dw ? bus.Dc_wb_wline : '0;
            end
            if (done && (state == BUSY_I))  f_line_q <= bus.Arb_mem_rline;
            if (done && (state == BUSY_DR)) d_line_q <= bus.Arb_mem_rline;
            if (grant_dr)     last_grant_d <= 1'b1;
            else if (grant_i) last_grant_d <= 1'b0;
        end
    end

    assign bus.Arb_mem_req   = req_q;
    assign bus.Arb_mem_we    = we_q;
    assign bus.Arb_mem_addr  = addr_q;
    assign bus.Arb_mem_wline = wline_q;
    assign bus.F_mem_inst    = f_line_q;
    assign bus.F_mem_valid   = f_valid_q;
    assign bus.MEM_data_line = d_line_q;
    assign bus.MEM_mem_valid = d_valid_q;
    assign bus.Dc_wb_done    = wb_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    localparam int AW = 10;
    localparam int LW = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [LW-1:0] mem [0:1023];

    // client stimulus: mode 0 manual, 1 drop on own pulse, 2 reassert at once, 3 random
    logic          ic_req, dc_req, wb_we, rst_s;
    logic [AW-1:0] ic_addr, dc_addr, wb_addr;
    logic [LW-1:0] wb_line;
    int            ic_mode, dc_mode, wb_mode;
    int            fixed_lat, lat, cnt;
    bit            force_valid;

    // reference model: one outstanding transaction, owner 0=I 1=D 2=WB
    bit            m_busy, m_we, m_last_d;
    int            m_owner;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wline, e_fline, e_dline;
    bit            ep_i, ep_d, ep_w;

    int glog[$];
    int grants, f_pulses, d_pulses, w_pulses;
    int req_first, req_last, f_cyc, start;
    bit prev_req;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] rand_addr(input logic [1:0] r);
        logic [7:0] lo;
        lo = 8'($urandom_range(15));
        return {r, lo};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_we = 0; m_last_d = 0; m_owner = 0;
        m_addr = '0; m_wline = '0; e_fline = '0; e_dline = '0;
        ep_i = 0; ep_d = 0; ep_w = 0;
    endtask

    task automatic tick();
        bit pi, pd, pw;
        @(negedge clk);
        cyc++;
        if (!rst) model_reset();
        chk("arb_req", LW'(bus.Arb_mem_req), LW'(m_busy));
        if (m_busy) begin
            chk("arb_we", LW'(bus.Arb_mem_we), LW'(m_we));
            chk("arb_addr", LW'(bus.Arb_mem_addr), LW'(m_addr));
            if (m_we) chk("arb_wline", bus.Arb_mem_wline, m_wline);
        end
        chk("f_valid", LW'(bus.F_mem_valid), LW'(ep_i));
        chk("mem_valid", LW'(bus.MEM_mem_valid), LW'(ep_d));
        chk("wb_done", LW'(bus.Dc_wb_done), LW'(ep_w));
        chk("f_inst", bus.F_mem_inst, e_fline);
        chk("mem_line", bus.MEM_data_line, e_dline);

        if (bus.Arb_mem_req && !prev_req) begin
            grants++;
            req_first = cyc;
            glog.push_back(bus.Arb_mem_we ? 2 : int'(bus.Arb_mem_addr[9:8]));
        end
        if (bus.Arb_mem_req) req_last = cyc;
        if (bus.F_mem_valid) f_cyc = cyc;
        prev_req = bus.Arb_mem_req;
        f_pulses += int'(bus.F_mem_valid);
        d_pulses += int'(bus.MEM_mem_valid);
        w_pulses += int'(bus.Dc_wb_done);

        if (bus.F_mem_valid) begin
            if (ic_mode == 1) ic_req = 0;
            else if (ic_mode == 2) ic_addr = rand_addr(2'd0);
            else if (ic_mode == 3) begin
                if ($urandom_range(1) == 1) ic_addr = rand_addr(2'd0); else ic_req = 0;
            end
        end else if (ic_mode == 3 && !ic_req && $urandom_range(2) == 0) begin
            ic_req = 1; ic_addr = rand_addr(2'd0);
        end
        if (bus.MEM_mem_valid) begin
            if (dc_mode == 1) dc_req = 0;
            else if (dc_mode == 2) dc_addr = rand_addr(2'd1);
            else if (dc_mode == 3) begin
                if ($urandom_range(1) == 1) dc_addr = rand_addr(2'd1); else dc_req = 0;
            end
        end else if (dc_mode == 3 && !dc_req && $urandom_range(2) == 0) begin
            dc_req = 1; dc_addr = rand_addr(2'd1);
        end
        if (bus.Dc_wb_done) begin
            if (wb_mode == 1) wb_we = 0;
            else if (wb_mode == 3) begin
                if ($urandom_range(1) == 1) begin
                    wb_addr = rand_addr(2'd1); wb_line = {$urandom, $urandom, $urandom, $urandom};
                end else wb_we = 0;
            end
        end else if (wb_mode == 3 && !wb_we && $urandom_range(3) == 0) begin
            wb_we = 1; wb_addr = rand_addr(2'd1); wb_line = {$urandom, $urandom, $urandom, $urandom};
        end

        rst = rst_s;
        bus.Ic_mem_req  = ic_req;  bus.Ic_mem_addr = ic_addr;
        bus.Dc_mem_req  = dc_req;  bus.Dc_mem_addr = dc_addr;
        bus.Dc_wb_we    = wb_we;   bus.Dc_wb_addr  = wb_addr;
        bus.Dc_wb_wline = wb_line;

        // backing memory: completes lat cycles after first seeing the request
        if (bus.Arb_mem_req) cnt++; else cnt = 0;
        if (cnt == 1) lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
        bus.Arb_mem_valid = force_valid || (bus.Arb_mem_req && cnt == lat + 1);
        force_valid = 0;
        bus.Arb_mem_rline = {$urandom, $urandom, $urandom, $urandom};
        if (bus.Arb_mem_valid && bus.Arb_mem_req) begin
            if (bus.Arb_mem_we) mem[bus.Arb_mem_addr] = bus.Arb_mem_wline;
            else bus.Arb_mem_rline = mem[bus.Arb_mem_addr];
        end

        if (rst) begin
            pw = wb_we && !ep_w;
            pd = dc_req && !ep_d;
            pi = ic_req && !ep_i;
            ep_i = 0; ep_d = 0; ep_w = 0;
            if (m_busy) begin
                if (bus.Arb_mem_valid) begin
                    m_busy = 0;
                    if (m_owner == 0) begin ep_i = 1; e_fline = bus.Arb_mem_rline; end
                    else if (m_owner == 1) begin ep_d = 1; e_dline = bus.Arb_mem_rline; end
                    else ep_w = 1;
                end
            end else if (pw || pd || pi) begin
                m_busy = 1;
                if (pw) begin
                    m_owner = 2; m_we = 1; m_addr = wb_addr; m_wline = wb_line;
                end else if (pd && (!pi || !m_last_d)) begin
                    m_owner = 1; m_we = 0; m_addr = dc_addr; m_last_d = 1;
                end else begin
                    m_owner = 0; m_we = 0; m_addr = ic_addr; m_last_d = 0;
                end
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        bit idle;
        idle = 0;
        for (int i = 0; i < 300; i++) begin
            if (!ic_req && !dc_req && !wb_we && !m_busy && !bus.Arb_mem_req) begin
                idle = 1;
                break;
            end
            tick();
        end
        chk(tag, LW'(idle), LW'(1));
    endtask

    task automatic clear_logs();
        glog.delete();
        grants = 0; f_pulses = 0; d_pulses = 0; w_pulses = 0;
        req_first = -1; req_last = -1; f_cyc = -1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        ic_req = 0; dc_req = 0; wb_we = 0; rst_s = 0;
        ic_addr = '0; dc_addr = '0; wb_addr = '0; wb_line = '0;
        ic_mode = 0; dc_mode = 0; wb_mode = 0;
        fixed_lat = 3; lat = 3; cnt = 0; force_valid = 0; prev_req = 0;
        bus.Ic_mem_req = 0; bus.Ic_mem_addr = '0; bus.Dc_mem_req = 0; bus.Dc_mem_addr = '0;
        bus.Dc_wb_we = 0; bus.Dc_wb_addr = '0; bus.Dc_wb_wline = '0;
        bus.Arb_mem_rline = '0; bus.Arb_mem_valid = 0;
        model_reset();
        clear_logs();

        // reset held, then requests present at release are not served early
        ic_req = 1; ic_addr = 10'h004;
        repeat (3) tick();
        chk("reset_no_grant", LW'(grants), LW'(0));
        ic_req = 0;
        rst_s = 1;
        tick();

        // single I-read, latency 3
        clear_logs();
        fixed_lat = 3;
        ic_addr = 10'h004; ic_req = 1; ic_mode = 1;
        start = cyc + 1;
        wait_idle("idle_single");
        chk("single_req_first", LW'(req_first - start), LW'(1));
        chk("single_req_last", LW'(req_last - start), LW'(4));
        chk("single_f_cycle", LW'(f_cyc - start), LW'(5));
        chk("single_f_count", LW'(f_pulses), LW'(1));
        chk("single_line", bus.F_mem_inst, mem[10'h004]);

        // simultaneous I and D reads: D first, then I
        clear_logs();
        fixed_lat = 2;
        ic_addr = 10'h0AA; dc_addr = 10'h155;
        ic_req = 1; dc_req = 1; ic_mode = 1; dc_mode = 1;
        wait_idle("idle_tie");
        chk("tie_grants", LW'(glog.size()), LW'(2));
        if (glog.size() == 2) begin
            chk("tie_first_d", LW'(glog[0]), LW'(1));
            chk("tie_second_i", LW'(glog[1]), LW'(0));
        end
        chk("tie_pulses", LW'(f_pulses + d_pulses), LW'(2));

        // write-back with both reads pending: WB, D, I
        clear_logs();
        wb_addr = 10'h010; wb_line = {16{8'hA5}};
        ic_addr = 10'h011; dc_addr = 10'h110;
        wb_we = 1; ic_req = 1; dc_req = 1; wb_mode = 1;
        wait_idle("idle_wb");
        chk("wb_grants", LW'(glog.size()), LW'(3));
        if (glog.size() == 3) begin
            chk("wb_order0", LW'(glog[0]), LW'(2));
            chk("wb_order1", LW'(glog[1]), LW'(1));
            chk("wb_order2", LW'(glog[2]), LW'(0));
        end
        chk("wb_done_count", LW'(w_pulses), LW'(1));
        chk("wb_mem_written", mem[10'h010], {16{8'hA5}});

        // continuous reads alternate D, I, D, I
        clear_logs();
        fixed_lat = 1;
        ic_addr = 10'h020; dc_addr = 10'h120;
        ic_req = 1; dc_req = 1; ic_mode = 2; dc_mode = 2;
        for (int i = 0; i < 300 && grants < 8; i++) tick();
        ic_mode = 1; dc_mode = 1;
        wait_idle("idle_alt");
        chk("alt_grant_count", LW'(glog.size() >= 8), LW'(1));
        if (glog.size() >= 8)
            for (int i = 0; i < 8; i++) chk($sformatf("alt_grant%0d", i), LW'(glog[i]), LW'(i % 2 == 0 ? 1 : 0));

        // reset one cycle before the D-read completes; a late valid is ignored
        clear_logs();
        fixed_lat = 3;
        dc_addr = 10'h123; dc_req = 1; dc_mode = 1;
        repeat (3) tick();
        @(posedge clk);
        #2;
        rst = 0; rst_s = 0; dc_req = 0; dc_mode = 0;
        #1;
        chk("arst_req", LW'(bus.Arb_mem_req), LW'(0));
        chk("arst_we", LW'(bus.Arb_mem_we), LW'(0));
        chk("arst_addr", LW'(bus.Arb_mem_addr), LW'(0));
        chk("arst_wline", bus.Arb_mem_wline, LW'(0));
        chk("arst_f_inst", bus.F_mem_inst, LW'(0));
        chk("arst_mem_line", bus.MEM_data_line, LW'(0));
        chk("arst_pulses", LW'({bus.F_mem_valid, bus.MEM_mem_valid, bus.Dc_wb_done}), LW'(0));
        repeat (2) tick();
        rst_s = 1;
        tick();
        force_valid = 1;
        repeat (3) tick();
        chk("arst_no_mem_valid", LW'(d_pulses), LW'(0));
        chk("arst_grants", LW'(grants), LW'(1));

        // I-read withdrawn mid-transaction still completes once
        clear_logs();
        fixed_lat = 4;
        ic_addr = 10'h033; ic_req = 1; ic_mode = 0;
        repeat (3) tick();
        ic_req = 0;
        repeat (8) tick();
        chk("drop_f_pulses", LW'(f_pulses), LW'(1));
        chk("drop_grants", LW'(grants), LW'(1));
        chk("drop_line", bus.F_mem_inst, mem[10'h033]);

        // randomized traffic checked cycle by cycle against the model
        clear_logs();
        fixed_lat = 0;
        ic_mode = 3; dc_mode = 3; wb_mode = 3;
        repeat (600) tick();
        ic_mode = 1; dc_mode = 1; wb_mode = 1;
        wait_idle("idle_random");
        chk("random_activity", LW'(grants > 20), LW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
